wb_uart_rx: RTL
===============

# wb_uart_rx

Serial UART receiver: the receive-side counterpart of the team's UART transmitter (8 data bits, no parity, 1 stop bit, LSB first). It synchronises the asynchronous `i_uart_rx` line, validates the start bit at mid-bit, samples eight data bits and the stop bit at mid-bit, and presents each byte as a one-cycle strobe. Framing errors and line breaks are flagged so that echo, command-parse or test tops can be built on it.

## Interface
- `CLOCKS_PER_BAUD`, default 24'd217 (25 MHz / 115 200): clocks per bit, 24-bit; legal range 4 to 2^24-1.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_uart_rx`  in  1  raw serial line; idles high; asynchronous to `i_clk`.
- `o_wr`  out  1  one-cycle strobe; `o_data` holds a valid received byte.
- `o_data`  out  8  last received byte; holds its value until the next `o_wr`.
- `o_frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `o_busy`  out  1  high whenever the state is not IDLE.

## Operation
- **Reset values.**
  - Synchroniser flops = 1.
  - State = IDLE; baud counter = 0; bit counter = 0.
  - `o_wr` = 0, `o_data` = 8'h00, `o_frame_err` = 0, `o_busy` = 0.
- **Synchroniser.** `i_uart_rx` passes through 2 flops. The second flop output, `rx_s`, is the only line value used by the rest of the block.
- **Baud counter.** 24-bit down-counter. It decrements every cycle while not in IDLE or WAIT_HIGH. A "sample point" is a cycle in which the counter is 0.
- **IDLE.** If `rx_s` = 0: load counter with `CLOCKS_PER_BAUD/2 - 1` (integer division), clear bit counter, go to START.
- **START, at sample point.**
  - `rx_s` = 0: load counter with `CLOCKS_PER_BAUD - 1` and go to DATA.
  - `rx_s` = 1: glitch; return to IDLE with no strobes.
- **DATA, at sample point.**
  - Shift: `shreg <= {rx_s, shreg[7:1]}` (LSB first).
  - Bit counter increments; reload counter with `CLOCKS_PER_BAUD - 1`.
  - When the bit counter was 7, go to STOP.
- **STOP, at sample point.**
  - `rx_s` = 1: `o_data <= shreg`, pulse `o_wr`, go to IDLE.
  - `rx_s` = 0: pulse `o_frame_err`, leave `o_data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH.** Stay until `rx_s` = 1, then go to IDLE. This prevents a held-low line (break) from re-triggering frames.
- **Mutual exclusion.** `o_wr` and `o_frame_err` are never high in the same cycle.
- **Strobes.** `o_wr` and `o_frame_err` are registered and high for exactly one cycle.
- **Reset mid-frame.** Abort immediately, return to the reset values, discard the partial byte, emit no strobe.

## Timing
- Let edge N be the first `i_clk` edge that captures `i_uart_rx` = 0 into sync flop 1.
- `rx_s` = 0 after edge N+1. The state enters START at edge N+2.
- Start-bit sample at edge N+2+`CLOCKS_PER_BAUD/2`. Data bit k is sampled `(k+1)*CLOCKS_PER_BAUD` later.
- Stop-bit sample at edge S = N+2+`CLOCKS_PER_BAUD/2`+9·`CLOCKS_PER_BAUD`. `o_wr`/`o_frame_err` is high for the one cycle after edge S.
- `o_busy` rises after edge N+2 and falls after edge S (or, on a framing error, once WAIT_HIGH exits).
- **Back-to-back frames.** A start bit arriving immediately after the stop bit is accepted. The block returns to IDLE at the stop-bit mid-point, which leaves half a bit of margin.
- **No backpressure.** The consumer must take `o_data` on `o_wr`. `o_data` stays stable for at least 10·`CLOCKS_PER_BAUD` cycles.

## Structure
- **Package `uart_pkg`** holds:
  - the state enum typedef: IDLE, START, DATA, STOP, WAIT_HIGH (3-bit);
  - `localparam DEFAULT_CLOCKS_PER_BAUD = 24'd217`.
- **Sub-module `rx_sync`**: 2-flop synchroniser with asynchronous active-low reset to 1. It is reused for any other asynchronous inputs.
- **Expected size.** One FSM `always_ff` plus the datapath; roughly 150–200 lines.

## Test plan
- **Single byte.** `CLOCKS_PER_BAUD`=8, reset released, send 8'h48 ('H') -> `o_wr` high exactly one cycle, after edge N+78; `o_data`=8'h48; `o_frame_err` never high.
- **Back-to-back bytes.** `CLOCKS_PER_BAUD`=8, "Hello World!\r\n" sent with no idle gap -> 14 `o_wr` pulses with the correct bytes in order, spaced 80 cycles apart.
- **Start-bit glitch.** Line low for 2 cycles, then high -> state returns to IDLE; `o_busy` pulses for fewer than 8 cycles; no `o_wr`, no `o_frame_err`.
- **Framing error and break.** Byte 8'hA5 sent with stop bit low, then line held low for 50 bit times -> exactly one `o_frame_err`, no `o_wr`, `o_data` unchanged. After the line returns high, 8'h3C is received correctly.
- **Reset mid-frame.** `i_rst_n` asserted during data bit 4 -> outputs return to reset values at once. The next full frame, 8'hFF, is received correctly.
- **Default rate.** `CLOCKS_PER_BAUD`=217, 8'h00 and 8'hFF sent at ±2% baud skew -> both bytes received without error.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   rx_state_t               - receiver FSM state encoding (3 bits)
//   DEFAULT_CLOCKS_PER_BAUD  - 25 MHz / 115 200 baud
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam logic [23:0] DEFAULT_CLOCKS_PER_BAUD = 24'd217;

endpackage

// File: rtl/rx_sync.sv
// rx_sync: two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to 1, which is the idle level of a UART line.
//   clk    in   sampling clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   asynchronous input
//   synced out  input re-timed to clk (two-cycle latency)
`timescale 1ns/1ps
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= 1'b1;
            synced <= 1'b1;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/wb_uart_rx.sv
// wb_uart_rx: 8N1 UART receiver, LSB first, mid-bit sampling.
//   i_clk        in   system clock
//   i_rst_n      in   asynchronous active-low reset
//   i_uart_rx    in   raw serial line (idles high, asynchronous)
//   o_wr         out  one-cycle strobe, o_data holds a new byte
//   o_data       out  last good byte, held until the next o_wr
//   o_frame_err  out  one-cycle strobe, stop bit sampled low
//   o_busy       out  high whenever a frame is in progress
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | timing to the middle of the start bit to reject glitches
// DATA      | sampling eight data bits at mid-bit
// STOP      | sampling the stop bit
// WAIT_HIGH | framing error seen, waiting for the line to return high
`timescale 1ns/1ps
module wb_uart_rx
    import uart_pkg::*;
#(
    parameter logic [23:0] CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic       o_wr,
    output logic [7:0] o_data,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam logic [23:0] HALF_LOAD = CLOCKS_PER_BAUD / 24'd2 - 24'd1;
    localparam logic [23:0] FULL_LOAD = CLOCKS_PER_BAUD - 24'd1;

    logic        rx_s;
    rx_state_t   state;
    logic [23:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        sample;

    rx_sync u_sync (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .raw    (i_uart_rx),
        .synced (rx_s)
    );

    assign sample = (baud_cnt == 24'd0);
    assign o_busy = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            baud_cnt    <= 24'd0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            o_data      <= 8'h00;
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;

            // Count down toward the next sample point; every sample point
            // either reloads the counter or leaves the timed states.
            if (state != IDLE && state != WAIT_HIGH && !sample)
                baud_cnt <= baud_cnt - 24'd1;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_LOAD;
                        bit_cnt  <= 3'd0;
                        state    <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (!rx_s) begin
                            baud_cnt <= FULL_LOAD;
                            state    <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg    <= {rx_s, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        baud_cnt <= FULL_LOAD;
                        if (bit_cnt == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    // Leaving at the stop-bit midpoint gives half a bit of
                    // margin to catch a back-to-back start bit.
                    if (sample) begin
                        if (rx_s) begin
                            o_data <= shreg;
                            o_wr   <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
